// File: rtl/systolic_subject_feeder_if.sv
// Element load channel into the subject feeder.
//   in_valid  master -> slave   element offered
//   in_ready  slave  -> master  feeder can take an element this cycle
//   in_data   master -> slave   matrix element, row-major order
interface systolic_subject_feeder_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/systolic_subject_feeder.sv
// Subject operand feeder for the west edge of an N x N PE array.
// Buffers one whole N x N matrix from a byte stream, replays it as N lanes
// with lane r delayed r cycles behind lane 0, then drives N cycles of zeros
// so the partial sums drain out of the array.
//
// Ports:
//   clk         rising-edge clock
//   clear       asynchronous active-low reset
//   feed        load channel (in_valid / in_ready / in_data)
//   abort       synchronous frame discard
//   subj_out    N lanes, lane r at [r*DATA_W +: DATA_W], to row r subject_in
//   lane_valid  lane r carries a real element this cycle
//   busy        streaming or flushing
//   done        one-cycle pulse when a frame completes
//
// state  | meaning
// IDLE   | no elements held, ready for element 0
// LOAD   | 1..N*N-1 elements held
// STREAM | skewed replay, step 0..2N-2
// FLUSH  | N cycles of zeros on every lane
module systolic_subject_feeder #(
   parameter int N      = 4,
   parameter int DATA_W = 8
) (
   input  logic                         clk,
   input  logic                         clear,
   systolic_subject_feeder_if.slave     feed,
   input  logic                         abort,
   output logic [N*DATA_W-1:0]          subj_out,
   output logic [N-1:0]                 lane_valid,
   output logic                         busy,
   output logic                         done
);
   localparam int CNT_W  = $clog2(N*N+1);
   localparam int STEP_W = $clog2(2*N);
   localparam int IDX_W  = $clog2(N*N);

   typedef enum logic [1:0] {IDLE, LOAD, STREAM, FLUSH} state_t;

   state_t                       state, state_nxt;
   logic [CNT_W-1:0]             elem_cnt, elem_cnt_nxt;
   logic [STEP_W-1:0]            step, step_nxt;
   logic [DATA_W-1:0]            buffer [N*N];
   logic [N-1:0][DATA_W-1:0]     lane_q, lane_nxt;
   logic [N-1:0]                 valid_nxt;
   logic                         busy_nxt, done_nxt;
   logic                         xfer, last_elem, step_end, flush_end;

   // abort wins over a same-edge transfer, so the element is simply dropped
   assign xfer      = feed.in_valid & feed.in_ready & ~abort;
   assign last_elem = (elem_cnt == CNT_W'(N*N-1));
   assign step_end  = (step == STEP_W'(2*N-2));
   assign flush_end = (step == STEP_W'(N-1));

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state    <= IDLE;
         elem_cnt <= '0;
         step     <= '0;
      end else begin
         state    <= state_nxt;
         elem_cnt <= elem_cnt_nxt;
         step     <= step_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      elem_cnt_nxt = elem_cnt;
      step_nxt     = step;
      if (abort) begin
         state_nxt    = IDLE;
         elem_cnt_nxt = '0;
         step_nxt     = '0;
      end else begin
         case (state)
            IDLE, LOAD: begin
               if (xfer) begin
                  if (last_elem) begin
                     state_nxt    = STREAM;
                     elem_cnt_nxt = '0;
                     step_nxt     = '0;
                  end else begin
                     state_nxt    = LOAD;
                     elem_cnt_nxt = elem_cnt + 1'b1;
                  end
               end
            end
            STREAM: begin
               if (step_end) begin
                  state_nxt = FLUSH;
                  step_nxt  = '0;
               end else begin
                  step_nxt  = step + 1'b1;
               end
            end
            FLUSH: begin
               if (flush_end) begin
                  state_nxt = IDLE;
                  step_nxt  = '0;
               end else begin
                  step_nxt  = step + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Outputs are registered, so they are computed from the next state/step.
   // On the edge that accepts the last element only buf[0][0] is read, which
   // was written long before.
   always_comb begin
      int d;
      feed.in_ready = (state == IDLE) || (state == LOAD);
      lane_nxt      = '0;
      valid_nxt     = '0;
      d             = 0;
      for (int r = 0; r < N; r++) begin
         d = int'(step_nxt) - r;
         if (state_nxt == STREAM && d >= 0 && d < N) begin
            lane_nxt[r]  = buffer[IDX_W'(r*N + d)];
            valid_nxt[r] = 1'b1;
         end
      end
      busy_nxt = (state_nxt == STREAM) || (state_nxt == FLUSH);
      done_nxt = (state == FLUSH) && flush_end && !abort;
   end

   // Buffer contents need no reset: they are always rewritten before replay.
   always_ff @(posedge clk) begin
      if (xfer) buffer[IDX_W'(elem_cnt)] <= feed.in_data;
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         lane_q     <= '0;
         lane_valid <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         lane_q     <= lane_nxt;
         lane_valid <= valid_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

   assign subj_out = lane_q;
endmodule

// File: tb/tb_systolic_subject_feeder.sv
module tb_systolic_subject_feeder;
   localparam int N      = 4;
   localparam int DATA_W = 8;

   logic                  clk   = 1'b0;
   logic                  clear = 1'b0;
   logic                  abort = 1'b0;
   logic [N*DATA_W-1:0]   subj_out;
   logic [N-1:0]          lane_valid;
   logic                  busy, done;
   int                    n_cmp = 0;
   int                    n_bad = 0;

   systolic_subject_feeder_if #(.DATA_W(DATA_W)) feed();

   systolic_subject_feeder #(.N(N), .DATA_W(DATA_W)) dut (
      .clk(clk), .clear(clear), .feed(feed), .abort(abort),
      .subj_out(subj_out), .lane_valid(lane_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Hand table for the 1..16 frame, cycles 1..7 after the last accept (lane 0 in low byte)
   logic [31:0] exp_tab [8] = '{32'h0, 32'h00000001, 32'h00000502, 32'h00090603,
                                32'h0D0A0704, 32'h0E0B0800, 32'h0F0C0000, 32'h10000000};
   logic [3:0]  vld_tab [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                4'b1111, 4'b1110, 4'b1100, 4'b1000};

   // Expected lanes for a frame of base..base+15; nonzero bytes shift by base-1
   function automatic logic [31:0] exp_lanes(input int c, input int base);
      logic [31:0] w;
      logic [31:0] t;
      w = '0;
      if (c >= 1 && c <= 7) begin
         t = exp_tab[c];
         for (int r = 0; r < N; r++)
            if (t[r*8 +: 8] != 8'd0) w[r*8 +: 8] = t[r*8 +: 8] + 8'(base - 1);
      end
      return w;
   endfunction

   function automatic logic [3:0] exp_valid(input int c);
      return (c >= 1 && c <= 7) ? vld_tab[c] : 4'b0000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1 time unit into cycle 1 after the last accept
   task automatic load_frame(input int base, input bit gaps);
      for (int k = 0; k < N*N; k++) begin
         if (gaps) begin
            feed.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
         end
         feed.in_valid = 1'b1;
         feed.in_data  = 8'(base + k);
         tick();
      end
      feed.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (subj_out !== '0)   begin n_bad++; $display("FAIL reset_subj got %h want 0", subj_out); end
      n_cmp++; if (lane_valid !== '0) begin n_bad++; $display("FAIL reset_valid got %b want 0", lane_valid); end
      n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
      @(negedge clk); clear = 1'b1;
      tick();
      n_cmp++; if (feed.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", feed.in_ready); end
      // reset in the middle of streaming
      load_frame(1, 1'b0);
      tick(); tick();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midreset_busy_before got %b want 1", busy); end
      #2 clear = 1'b0;
      #1;
      n_cmp++; if (subj_out !== '0)   begin n_bad++; $display("FAIL midreset_subj got %h want 0", subj_out); end
      n_cmp++; if (lane_valid !== '0) begin n_bad++; $display("FAIL midreset_valid got %b want 0", lane_valid); end
      n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL midreset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL midreset_done got %b want 0", done); end
      @(negedge clk); clear = 1'b1;
      for (int c = 0; c < 3*N+2; c++) begin
         tick();
         n_cmp++; if (done !== 1'b0 || feed.in_ready !== 1'b1)
            begin n_bad++; $display("FAIL midreset_idle c=%0d done=%b ready=%b want 0/1", c, done, feed.in_ready); end
      end
   endtask

   task automatic test_back_to_back();
      load_frame(1, 1'b0);
      for (int c = 1; c <= 3*N; c++) begin
         n_cmp++; if (subj_out !== exp_lanes(c, 1))
            begin n_bad++; $display("FAIL b2b_lanes c=%0d got %h want %h", c, subj_out, exp_lanes(c, 1)); end
         n_cmp++; if (lane_valid !== exp_valid(c))
            begin n_bad++; $display("FAIL b2b_valid c=%0d got %b want %b", c, lane_valid, exp_valid(c)); end
         n_cmp++; if (busy !== (c < 3*N))
            begin n_bad++; $display("FAIL b2b_busy c=%0d got %b want %b", c, busy, c < 3*N); end
         n_cmp++; if (done !== (c == 3*N))
            begin n_bad++; $display("FAIL b2b_done c=%0d got %b want %b", c, done, c == 3*N); end
         n_cmp++; if (feed.in_ready !== (c == 3*N))
            begin n_bad++; $display("FAIL b2b_ready c=%0d got %b want %b", c, feed.in_ready, c == 3*N); end
         tick();
      end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_width got %b want 0", done); end
   endtask

   task automatic test_bubbles();
      load_frame(1, 1'b1);
      for (int c = 1; c <= 3*N; c++) begin
         n_cmp++; if (subj_out !== exp_lanes(c, 1))
            begin n_bad++; $display("FAIL bub_lanes c=%0d got %h want %h", c, subj_out, exp_lanes(c, 1)); end
         n_cmp++; if (lane_valid !== exp_valid(c))
            begin n_bad++; $display("FAIL bub_valid c=%0d got %b want %b", c, lane_valid, exp_valid(c)); end
         n_cmp++; if (done !== (c == 3*N))
            begin n_bad++; $display("FAIL bub_done c=%0d got %b want %b", c, done, c == 3*N); end
         tick();
      end
   endtask

   task automatic test_backpressure();
      load_frame(1, 1'b0);
      feed.in_valid = 1'b1;
      feed.in_data  = 8'hAA;
      for (int c = 1; c <= 3*N; c++) begin
         n_cmp++; if (feed.in_ready !== (c == 3*N))
            begin n_bad++; $display("FAIL bp_ready c=%0d got %b want %b", c, feed.in_ready, c == 3*N); end
         if (c < 3*N) tick();
      end
      tick();   // 0xAA taken as element 0 here
      for (int k = 1; k < N*N; k++) begin
         feed.in_data = 8'(1 + k);
         tick();
      end
      feed.in_valid = 1'b0;
      n_cmp++; if (subj_out !== 32'h000000AA)
         begin n_bad++; $display("FAIL bp_first got %h want 000000aa", subj_out); end
      tick();
      n_cmp++; if (subj_out !== exp_lanes(2, 1))
         begin n_bad++; $display("FAIL bp_second got %h want %h", subj_out, exp_lanes(2, 1)); end
      repeat (3*N-2) tick();
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL bp_done got %b want 1", done); end
      tick();
   endtask

   task automatic test_abort_load();
      for (int k = 0; k < 5; k++) begin
         feed.in_valid = 1'b1;
         feed.in_data  = 8'(50 + k);
         tick();
      end
      abort = 1'b1;
      feed.in_data = 8'h77;
      tick();
      abort = 1'b0;
      feed.in_valid = 1'b0;
      n_cmp++; if (feed.in_ready !== 1'b1 || busy !== 1'b0)
         begin n_bad++; $display("FAIL abl_idle ready=%b busy=%b want 1/0", feed.in_ready, busy); end
      load_frame(101, 1'b0);
      for (int c = 1; c <= 3*N; c++) begin
         n_cmp++; if (subj_out !== exp_lanes(c, 101))
            begin n_bad++; $display("FAIL abl_lanes c=%0d got %h want %h", c, subj_out, exp_lanes(c, 101)); end
         n_cmp++; if (done !== (c == 3*N))
            begin n_bad++; $display("FAIL abl_done c=%0d got %b want %b", c, done, c == 3*N); end
         tick();
      end
   endtask

   task automatic test_abort_stream();
      load_frame(1, 1'b0);
      tick(); tick();
      n_cmp++; if (subj_out !== exp_lanes(3, 1))
         begin n_bad++; $display("FAIL abs_c3 got %h want %h", subj_out, exp_lanes(3, 1)); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_cmp++; if (subj_out !== '0)   begin n_bad++; $display("FAIL abs_subj got %h want 0", subj_out); end
      n_cmp++; if (lane_valid !== '0) begin n_bad++; $display("FAIL abs_valid got %b want 0", lane_valid); end
      n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL abs_busy got %b want 0", busy); end
      n_cmp++; if (feed.in_ready !== 1'b1) begin n_bad++; $display("FAIL abs_ready got %b want 1", feed.in_ready); end
      for (int c = 0; c < 3*N; c++) begin
         n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abs_nodone c=%0d got %b want 0", c, done); end
         tick();
      end
   endtask

   initial begin
      feed.in_valid = 1'b0;
      feed.in_data  = '0;
      test_reset();
      test_back_to_back();
      test_bubbles();
      test_backpressure();
      test_abort_load();
      test_abort_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
